if_id_queue: RTL and testbench

// Decoupling queue between the instruction-fetch stage and the decode stage.
// - Captures each fetched {instruction, PC} pair and presents it in order to decode.
// - Uses a valid/ready handshake on both sides, so a decode stall does not drop fetched words.
// - A flush input discards all queued entries when a taken branch redirects fetch.
// - A saturating counter records decode-starved (bubble) cycles for performance analysis.

---
 rtl/if_id_queue_if.sv | 37 +++
 rtl/if_id_queue.sv | 91 +++++++++
 tb/tb_if_id_queue.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch/decode handshake bundle for the IF/ID queue
interface if_id_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   // fetch side
   logic            in_valid;
   logic [XLEN-1:0] in_instr;
   logic [XLEN-1:0] in_pc;
   logic            in_ready;
   logic            flush;

   // decode side
   logic            out_valid;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic            out_ready;

   // status
   logic [CW-1:0]    count;
   logic [CNT_W-1:0] bubble_cnt;

   // fetch/decode/flush driver view
   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, count, bubble_cnt
   );

   // queue view
   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_instr, out_pc, count, bubble_cnt
   );
endinterface

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - in-order decoupling queue between fetch and decode
module if_id_queue #(
   parameter int              XLEN      = 32,
   parameter int              DEPTH     = 2,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013,
   parameter int              CNT_W     = 16
) (
   input logic            clk,
   input logic            rst,
   if_id_queue_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ONE  = 1;
   localparam logic [CW-1:0]    CNT_ONE  = 1;
   localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
   localparam logic [CNT_W-1:0] BUB_ONE  = 1;
   localparam logic [CNT_W-1:0] BUB_MAX  = '1;

   // entry storage; contents are only observed through count-qualified reads
   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [XLEN-1:0] pc_mem    [DEPTH];

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CW-1:0]    count;
   logic [CNT_W-1:0] bubble_cnt;

   logic in_ready;
   logic out_valid;
   logic push;
   logic pop;

   // handshake qualifiers; in_ready deliberately ignores out_ready
   always_comb begin
      in_ready  = (count != CNT_FULL);
      out_valid = (count != '0);
      push      = bus.in_valid & in_ready;
      pop       = out_valid & bus.out_ready;
   end

   // write the accepted word into the tail slot (a flush discards it)
   always_ff @(posedge clk) begin
      if (push && !bus.flush) begin
         instr_mem[wr_ptr] <= bus.in_instr;
         pc_mem[wr_ptr]    <= bus.in_pc;
      end
   end

   // pointer and occupancy tracking; flush wins over push/pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (bus.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // starved-decode counter: decode ready, nothing to give, no redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bubble_cnt <= '0;
      else if (bus.out_ready && !out_valid && !bus.flush && bubble_cnt != BUB_MAX)
         bubble_cnt <= bubble_cnt + BUB_ONE;
   end

   // present the head entry, or a NOP while empty
   always_comb begin
      bus.in_ready   = in_ready;
      bus.out_valid  = out_valid;
      bus.out_instr  = out_valid ? instr_mem[rd_ptr] : NOP_INSTR;
      bus.out_pc     = out_valid ? pc_mem[rd_ptr] : '0;
      bus.count      = count;
      bus.bubble_cnt = bubble_cnt;
   end
endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue
`timescale 1ns/1ps
module tb_if_id_queue;
   localparam int XLEN  = 32;
   localparam int DEPTH = 2;
   localparam int CNT_W = 16;
   localparam logic [31:0] NOP = 32'h00000013;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   if_id_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: a plain FIFO of {instr,pc} plus a bubble tally
   logic [63:0] mq[$];
   int unsigned mbub = 0;

   initial begin
      bit mrdy, mval, mpush, mpop;
      forever begin
         @(posedge clk);
         if (rst) begin
            mq.delete();
            mbub = 0;
         end else begin
            mrdy  = (mq.size() != DEPTH);
            mval  = (mq.size() != 0);
            mpush = bus.in_valid && mrdy;
            mpop  = bus.out_ready && mval;
            if (bus.flush) begin
               mq.delete();
            end else begin
               if (mpop)  void'(mq.pop_front());
               if (mpush) mq.push_back({bus.in_instr, bus.in_pc});
            end
            if (bus.out_ready && !mval && !bus.flush && mbub < 65535) mbub++;
         end
         #1;
         chk("m_count",     64'(bus.count),      64'(mq.size()));
         chk("m_out_valid", 64'(bus.out_valid),  64'(mq.size() != 0));
         chk("m_in_ready",  64'(bus.in_ready),   64'(mq.size() != DEPTH));
         chk("m_out_instr", 64'(bus.out_instr),  64'(mq.size() != 0 ? mq[0][63:32] : NOP));
         chk("m_out_pc",    64'(bus.out_pc),     64'(mq.size() != 0 ? mq[0][31:0] : 32'h0));
         chk("m_bubble",    64'(bus.bubble_cnt), 64'(mbub));
      end
   end

   task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                        input logic rdy, input logic fl);
      bus.in_valid  = v;
      bus.in_instr  = i;
      bus.in_pc     = p;
      bus.out_ready = rdy;
      bus.flush     = fl;
      @(negedge clk);
   endtask

   initial begin
      bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.out_ready = 0; bus.flush = 0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(bus.out_valid), 0);
      chk("rst_in_ready",  64'(bus.in_ready), 1);
      chk("rst_count",     64'(bus.count), 0);
      chk("rst_out_instr", 64'(bus.out_instr), 64'h13);
      chk("rst_bubble",    64'(bus.bubble_cnt), 0);

      // ordering, one cycle latency
      drive(1, 32'h00500093, 32'h0, 1, 0);
      chk("ord_instr0", 64'(bus.out_instr), 64'h00500093);
      chk("ord_pc0",    64'(bus.out_pc), 0);
      drive(1, 32'h00A00113, 32'h4, 1, 0);
      chk("ord_instr1", 64'(bus.out_instr), 64'h00A00113);
      chk("ord_pc1",    64'(bus.out_pc), 4);
      drive(0, 0, 0, 1, 0);
      chk("ord_empty", 64'(bus.out_instr), 64'h13);

      // backpressure, full refusal, full with simultaneous pop
      drive(1, 32'hAAAA0001, 32'h8, 0, 0);
      drive(1, 32'hBBBB0002, 32'hC, 0, 0);
      chk("bp_count2",  64'(bus.count), 2);
      chk("bp_inready", 64'(bus.in_ready), 0);
      drive(1, 32'hCCCC0003, 32'h10, 0, 0);
      chk("bp_refused", 64'(bus.count), 2);
      chk("bp_head",    64'(bus.out_instr), 64'hAAAA0001);
      drive(1, 32'hCCCC0003, 32'h10, 1, 0);
      chk("fullpop_count", 64'(bus.count), 1);
      chk("fullpop_head",  64'(bus.out_instr), 64'hBBBB0002);
      drive(1, 32'hCCCC0003, 32'h10, 1, 0);
      chk("bp_third_head", 64'(bus.out_instr), 64'hCCCC0003);
      chk("bp_third_pc",   64'(bus.out_pc), 64'h10);
      drive(0, 0, 0, 1, 0);
      chk("bp_drained", 64'(bus.count), 0);

      // flush with concurrent push
      drive(1, 32'h11110001, 32'h20, 0, 0);
      drive(1, 32'h22220002, 32'h24, 0, 0);
      chk("fl_pre_count", 64'(bus.count), 2);
      drive(1, 32'hDDDD0004, 32'h28, 1, 1);
      chk("fl_count",   64'(bus.count), 0);
      chk("fl_valid",   64'(bus.out_valid), 0);
      chk("fl_inready", 64'(bus.in_ready), 1);
      drive(0, 0, 0, 0, 0);
      chk("fl_absent", 64'(bus.count), 0);

      // asynchronous reset mid-operation
      drive(1, 32'h33330003, 32'h30, 0, 0);
      chk("ar_pre", 64'(bus.count), 1);
      rst = 1'b1;
      #1;
      chk("ar_count", 64'(bus.count), 0);
      chk("ar_valid", 64'(bus.out_valid), 0);
      drive(0, 0, 0, 0, 0);
      rst = 1'b0;
      chk("ar_bubble", 64'(bus.bubble_cnt), 0);

      // bubble counting and saturation
      bus.out_ready = 1;
      repeat (5) @(negedge clk);
      chk("bub_5", 64'(bus.bubble_cnt), 5);
      repeat (65536 + 3 - 5) @(negedge clk);
      chk("bub_sat", 64'(bus.bubble_cnt), 64'hFFFF);
      @(negedge clk);
      chk("bub_hold", 64'(bus.bubble_cnt), 64'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
